// File: rtl/ex_stage_if.sv
// Bundle of every signal that runs between ID/EX, MEM/WB and the execute stage.
// The master side drives the id_ex_*, mem_wb_* and flush inputs. The slave side
// is the execute stage, which returns ex_stall and the ex_mem_* register outputs.
interface ex_stage_if;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc_plus4;
    logic [31:0] id_ex_reg_a_data;
    logic [31:0] id_ex_reg_b_data;
    logic [31:0] id_ex_imm;
    logic [25:0] id_ex_jump_target;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic [3:0]  id_ex_ctrl_alu_op;
    logic        id_ex_ctrl_alu_src;
    logic        id_ex_ctrl_reg_dst;
    logic        id_ex_ctrl_reg_write;
    logic        id_ex_ctrl_mem_to_reg;
    logic        id_ex_ctrl_mem_write;
    logic        id_ex_ctrl_branch_eq;
    logic        id_ex_ctrl_branch_neq;
    logic        id_ex_ctrl_jump;
    logic        mem_wb_ctrl_reg_write;
    logic [4:0]  mem_wb_write_reg_dst;
    logic [31:0] mem_wb_data;
    logic        flush;
    logic        ex_stall;
    logic        ex_mem_ctrl_reg_write;
    logic        ex_mem_ctrl_mem_to_reg;
    logic        ex_mem_ctrl_mem_write;
    logic        ex_mem_ctrl_branch_eq;
    logic        ex_mem_ctrl_branch_neq;
    logic        ex_mem_ctrl_jump;
    logic [31:0] ex_mem_alu_out;
    logic        ex_mem_alu_zero;
    logic [31:0] ex_mem_reg_b_data;
    logic [4:0]  ex_mem_write_reg_dst;
    logic [31:0] ex_mem_pc_branch;
    logic [31:0] ex_mem_pc_jump;

    modport master (
        output id_ex_valid, id_ex_pc_plus4, id_ex_reg_a_data, id_ex_reg_b_data,
               id_ex_imm, id_ex_jump_target, id_ex_rs, id_ex_rt, id_ex_rd,
               id_ex_ctrl_alu_op, id_ex_ctrl_alu_src, id_ex_ctrl_reg_dst,
               id_ex_ctrl_reg_write, id_ex_ctrl_mem_to_reg, id_ex_ctrl_mem_write,
               id_ex_ctrl_branch_eq, id_ex_ctrl_branch_neq, id_ex_ctrl_jump,
               mem_wb_ctrl_reg_write, mem_wb_write_reg_dst, mem_wb_data, flush,
        input  ex_stall, ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg,
               ex_mem_ctrl_mem_write, ex_mem_ctrl_branch_eq, ex_mem_ctrl_branch_neq,
               ex_mem_ctrl_jump, ex_mem_alu_out, ex_mem_alu_zero, ex_mem_reg_b_data,
               ex_mem_write_reg_dst, ex_mem_pc_branch, ex_mem_pc_jump
    );

    modport slave (
        input  id_ex_valid, id_ex_pc_plus4, id_ex_reg_a_data, id_ex_reg_b_data,
               id_ex_imm, id_ex_jump_target, id_ex_rs, id_ex_rt, id_ex_rd,
               id_ex_ctrl_alu_op, id_ex_ctrl_alu_src, id_ex_ctrl_reg_dst,
               id_ex_ctrl_reg_write, id_ex_ctrl_mem_to_reg, id_ex_ctrl_mem_write,
               id_ex_ctrl_branch_eq, id_ex_ctrl_branch_neq, id_ex_ctrl_jump,
               mem_wb_ctrl_reg_write, mem_wb_write_reg_dst, mem_wb_data, flush,
        output ex_stall, ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg,
               ex_mem_ctrl_mem_write, ex_mem_ctrl_branch_eq, ex_mem_ctrl_branch_neq,
               ex_mem_ctrl_jump, ex_mem_alu_out, ex_mem_alu_zero, ex_mem_reg_b_data,
               ex_mem_write_reg_dst, ex_mem_pc_branch, ex_mem_pc_jump
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// It forwards the operands, runs the ALU and computes the branch and jump
// targets, then registers the EX/MEM fields. MUL is handled by a shift-add
// multiplier that takes DATA_W+2 cycles. The stage holds the front end with
// ex_stall while the multiplier is busy.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int MUL_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    localparam int   CNT_W  = $clog2(DATA_W) + 1;
    localparam bit   MUL_ON = (MUL_EN != 0);
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_count;

    // Control bits in this order: reg_write, mem_to_reg, mem_write, branch_eq, branch_neq, jump.
    logic [5:0]          r_ctrl;
    logic [DATA_W-1:0]   r_alu_out;
    logic                r_alu_zero;
    logic [DATA_W-1:0]   r_reg_b_data;
    logic [4:0]          r_write_reg_dst;
    logic [DATA_W-1:0]   r_pc_branch;
    logic [DATA_W-1:0]   r_pc_jump;

    logic [DATA_W-1:0]   w_fwd_a;
    logic [DATA_W-1:0]   w_fwd_b;
    logic [DATA_W-1:0]   w_b_op;
    logic [DATA_W-1:0]   w_alu_res;
    logic [DATA_W-1:0]   w_acc_step;
    logic                w_is_mul;
    logic                w_stall;
    logic                w_write;

    // Operand forwarding. The younger EX/MEM result wins over MEM/WB, and register 0 never forwards.
    always_comb begin
        w_fwd_a = bus.id_ex_reg_a_data;
        if (r_ctrl[5] && r_write_reg_dst != 5'd0 && r_write_reg_dst == bus.id_ex_rs)
            w_fwd_a = r_alu_out;
        else if (bus.mem_wb_ctrl_reg_write && bus.mem_wb_write_reg_dst != 5'd0 &&
                 bus.mem_wb_write_reg_dst == bus.id_ex_rs)
            w_fwd_a = bus.mem_wb_data;

        w_fwd_b = bus.id_ex_reg_b_data;
        if (r_ctrl[5] && r_write_reg_dst != 5'd0 && r_write_reg_dst == bus.id_ex_rt)
            w_fwd_b = r_alu_out;
        else if (bus.mem_wb_ctrl_reg_write && bus.mem_wb_write_reg_dst != 5'd0 &&
                 bus.mem_wb_write_reg_dst == bus.id_ex_rt)
            w_fwd_b = bus.mem_wb_data;
    end

    assign w_b_op     = bus.id_ex_ctrl_alu_src ? bus.id_ex_imm : w_fwd_b;
    assign w_is_mul   = bus.id_ex_valid && (bus.id_ex_ctrl_alu_op == OP_MUL);
    assign w_stall    = rst_n && MUL_ON && w_is_mul && (r_state != ST_DONE) && !bus.flush;
    assign w_write    = bus.id_ex_valid && !bus.flush && !w_stall;
    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // ALU result. The MUL result is the finished accumulator, which is only meaningful in DONE.
    always_comb begin
        w_alu_res = '0;
        case (bus.id_ex_ctrl_alu_op)
            4'd0: w_alu_res = w_fwd_a + w_b_op;
            4'd1: w_alu_res = w_fwd_a - w_b_op;
            4'd2: w_alu_res = w_fwd_a & w_b_op;
            4'd3: w_alu_res = w_fwd_a | w_b_op;
            4'd4: w_alu_res = w_fwd_a ^ w_b_op;
            4'd5: w_alu_res = ~(w_fwd_a | w_b_op);
            4'd6: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_b_op))};
            4'd7: w_alu_res = {{(DATA_W-1){1'b0}}, (w_fwd_a < w_b_op)};
            4'd8: w_alu_res = {bus.id_ex_imm[15:0], 16'h0000};
            4'd9: w_alu_res = MUL_ON ? r_acc : '0;
            default: w_alu_res = '0;
        endcase
    end

    // Multiplier FSM. It processes one multiplier bit per BUSY cycle, and flush aborts it from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (MUL_ON && w_is_mul) begin
                        r_mcand  <= w_fwd_a;
                        r_mplier <= w_b_op;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == CNT_W'(DATA_W - 1))
                        r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // EX/MEM register. Control bits are zeroed for bubbles, and the data fields always take the computed values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl          <= '0;
            r_alu_out       <= '0;
            r_alu_zero      <= 1'b0;
            r_reg_b_data    <= '0;
            r_write_reg_dst <= '0;
            r_pc_branch     <= '0;
            r_pc_jump       <= '0;
        end else begin
            r_ctrl          <= w_write ? {bus.id_ex_ctrl_reg_write, bus.id_ex_ctrl_mem_to_reg,
                                          bus.id_ex_ctrl_mem_write, bus.id_ex_ctrl_branch_eq,
                                          bus.id_ex_ctrl_branch_neq, bus.id_ex_ctrl_jump} : 6'd0;
            r_alu_out       <= w_alu_res;
            r_alu_zero      <= (w_alu_res == '0);
            r_reg_b_data    <= w_fwd_b;
            r_write_reg_dst <= bus.id_ex_ctrl_reg_dst ? bus.id_ex_rd : bus.id_ex_rt;
            r_pc_branch     <= bus.id_ex_pc_plus4 + (bus.id_ex_imm << 2);
            r_pc_jump       <= {bus.id_ex_pc_plus4[31:28], bus.id_ex_jump_target, 2'b00};
        end
    end

    assign bus.ex_stall               = w_stall;
    assign bus.ex_mem_ctrl_reg_write  = r_ctrl[5];
    assign bus.ex_mem_ctrl_mem_to_reg = r_ctrl[4];
    assign bus.ex_mem_ctrl_mem_write  = r_ctrl[3];
    assign bus.ex_mem_ctrl_branch_eq  = r_ctrl[2];
    assign bus.ex_mem_ctrl_branch_neq = r_ctrl[1];
    assign bus.ex_mem_ctrl_jump       = r_ctrl[0];
    assign bus.ex_mem_alu_out         = r_alu_out;
    assign bus.ex_mem_alu_zero        = r_alu_zero;
    assign bus.ex_mem_reg_b_data      = r_reg_b_data;
    assign bus.ex_mem_write_reg_dst   = r_write_reg_dst;
    assign bus.ex_mem_pc_branch       = r_pc_branch;
    assign bus.ex_mem_pc_jump         = r_pc_jump;
endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage.
// Directed steps come first, then a randomized run. Every cycle is compared
// against a reference model of the EX/MEM register that is computed with plain
// arithmetic, including a cycle count for the MUL latency.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ex_stage_if bus();

    ex_stage #(.DATA_W(32), .MUL_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model of the EX/MEM register contents.
    logic [5:0]  m_ctrl;
    logic        m_wr;
    logic [31:0] m_alu, m_b, m_pcb, m_pcj, m_prod;
    logic        m_zero;
    logic [4:0]  m_dst;
    int          m_cnt;
    logic        m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (m_ctrl[5] && m_dst != 0 && m_dst == r) return m_alu;
        if (bus.mem_wb_ctrl_reg_write && bus.mem_wb_write_reg_dst != 0 && bus.mem_wb_write_reg_dst == r)
            return bus.mem_wb_data;
        return d;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7: return (a < b) ? 32'd1 : 32'd0;
            8: return {imm[15:0], 16'h0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_wr = 0; m_alu = 0; m_b = 0; m_pcb = 0; m_pcj = 0;
        m_zero = 0; m_dst = 0; m_cnt = 0; m_prod = 0; m_stall = 0;
    endtask

    task automatic check_outputs();
        chk("ctrl", {26'd0, bus.ex_mem_ctrl_reg_write, bus.ex_mem_ctrl_mem_to_reg, bus.ex_mem_ctrl_mem_write,
                     bus.ex_mem_ctrl_branch_eq, bus.ex_mem_ctrl_branch_neq, bus.ex_mem_ctrl_jump},
            {26'd0, m_ctrl});
        if (m_wr) begin
            chk("alu_out", bus.ex_mem_alu_out, m_alu);
            chk("alu_zero", {31'd0, bus.ex_mem_alu_zero}, {31'd0, m_zero});
            chk("reg_b", bus.ex_mem_reg_b_data, m_b);
            chk("dst", {27'd0, bus.ex_mem_write_reg_dst}, {27'd0, m_dst});
            chk("pc_branch", bus.ex_mem_pc_branch, m_pcb);
            chk("pc_jump", bus.ex_mem_pc_jump, m_pcj);
        end
    endtask

    // One clock cycle. Inputs are already driven. Check the stall, advance the model, then check the registers.
    task automatic step();
        logic        mul, wr;
        logic [31:0] a, b, bop, res;
        int          cnt_n;
        #1;
        mul = bus.id_ex_valid && bus.id_ex_ctrl_alu_op == 9 && !bus.flush;
        m_stall = mul && (m_cnt != 33);
        chk("stall", {31'd0, bus.ex_stall}, {31'd0, m_stall});
        a   = fwd(bus.id_ex_rs, bus.id_ex_reg_a_data);
        b   = fwd(bus.id_ex_rt, bus.id_ex_reg_b_data);
        bop = bus.id_ex_ctrl_alu_src ? bus.id_ex_imm : b;
        if (bus.flush) cnt_n = 0;
        else if (mul) begin
            if (m_cnt == 0) m_prod = a * bop;
            cnt_n = (m_cnt == 33) ? 0 : m_cnt + 1;
        end else cnt_n = m_cnt;
        res = (bus.id_ex_ctrl_alu_op == 9) ? m_prod : alu_ref(bus.id_ex_ctrl_alu_op, a, bop, bus.id_ex_imm);
        wr  = bus.id_ex_valid && !bus.flush && !m_stall;
        @(posedge clk);
        #1;
        m_wr   = wr;
        m_ctrl = wr ? {bus.id_ex_ctrl_reg_write, bus.id_ex_ctrl_mem_to_reg, bus.id_ex_ctrl_mem_write,
                       bus.id_ex_ctrl_branch_eq, bus.id_ex_ctrl_branch_neq, bus.id_ex_ctrl_jump} : 6'd0;
        m_alu  = res;
        m_zero = (res == 0);
        m_b    = b;
        m_dst  = bus.id_ex_ctrl_reg_dst ? bus.id_ex_rd : bus.id_ex_rt;
        m_pcb  = bus.id_ex_pc_plus4 + (bus.id_ex_imm << 2);
        m_pcj  = {bus.id_ex_pc_plus4[31:28], bus.id_ex_jump_target, 2'b00};
        m_cnt  = cnt_n;
        check_outputs();
    endtask

    task automatic instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic rdst, input logic [5:0] ctrl);
        bus.id_ex_valid = 1; bus.id_ex_ctrl_alu_op = op;
        bus.id_ex_rs = rs; bus.id_ex_rt = rt; bus.id_ex_rd = rd;
        bus.id_ex_reg_a_data = a; bus.id_ex_reg_b_data = b; bus.id_ex_imm = imm;
        bus.id_ex_ctrl_alu_src = src; bus.id_ex_ctrl_reg_dst = rdst;
        {bus.id_ex_ctrl_reg_write, bus.id_ex_ctrl_mem_to_reg, bus.id_ex_ctrl_mem_write,
         bus.id_ex_ctrl_branch_eq, bus.id_ex_ctrl_branch_neq, bus.id_ex_ctrl_jump} = ctrl;
    endtask

    task automatic wb(input logic rw, input logic [4:0] dst, input logic [31:0] d);
        bus.mem_wb_ctrl_reg_write = rw; bus.mem_wb_write_reg_dst = dst; bus.mem_wb_data = d;
    endtask

    task automatic check_zero_state(input string tag);
        chk({tag, "_ctrl"}, {26'd0, bus.ex_mem_ctrl_reg_write, bus.ex_mem_ctrl_mem_to_reg,
             bus.ex_mem_ctrl_mem_write, bus.ex_mem_ctrl_branch_eq, bus.ex_mem_ctrl_branch_neq,
             bus.ex_mem_ctrl_jump}, 32'd0);
        chk({tag, "_alu"}, bus.ex_mem_alu_out, 32'd0);
        chk({tag, "_dst"}, {27'd0, bus.ex_mem_write_reg_dst}, 32'd0);
        chk({tag, "_pcb"}, bus.ex_mem_pc_branch, 32'd0);
        chk({tag, "_stall"}, {31'd0, bus.ex_stall}, 32'd0);
    endtask

    initial begin
        int stall_cycles;
        bus.id_ex_pc_plus4 = 0; bus.id_ex_jump_target = 0; bus.flush = 0;
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0);
        bus.id_ex_valid = 0;
        wb(0, 0, 0);
        model_reset();

        // Reset state.
        @(posedge clk); #1;
        check_zero_state("reset");
        rst_n = 1;

        // ADD r3 = r1 + r2.
        instr(0, 1, 2, 3, 5, 7, 0, 0, 1, 6'b100000);
        step();
        chk("add_12", bus.ex_mem_alu_out, 32'd12);
        chk("add_dst3", {27'd0, bus.ex_mem_write_reg_dst}, 32'd3);
        chk("add_rw", {31'd0, bus.ex_mem_ctrl_reg_write}, 32'd1);

        // r4 = r3 + r3, with both operands forwarded from EX/MEM.
        instr(0, 3, 3, 4, 0, 0, 0, 0, 1, 6'b100000);
        step();
        chk("fwd_exmem_24", bus.ex_mem_alu_out, 32'd24);

        // The rs operand matches MEM/WB only.
        wb(1, 5, 100);
        instr(0, 5, 0, 6, 1, 0, 0, 0, 1, 6'b100000);
        step();
        chk("fwd_memwb_100", bus.ex_mem_alu_out, 32'd100);

        // Both stages match rs, and the EX/MEM value of 100 wins over the MEM/WB value.
        wb(1, 6, 32'h55);
        instr(0, 6, 0, 7, 0, 0, 0, 0, 1, 6'b100000);
        step();
        chk("fwd_priority", bus.ex_mem_alu_out, 32'd100);

        // A write to register 0 never forwards.
        instr(0, 1, 2, 0, 32'h70, 7, 0, 0, 1, 6'b100000);
        step();
        wb(1, 0, 32'h999);
        instr(0, 0, 0, 7, 3, 4, 0, 0, 1, 6'b100000);
        step();
        chk("fwd_r0", bus.ex_mem_alu_out, 32'd7);

        // BEQ computes SUB 9-9 and the branch target.
        wb(0, 0, 0);
        bus.id_ex_pc_plus4 = 32'h100;
        instr(1, 1, 2, 0, 9, 9, 4, 0, 0, 6'b000100);
        step();
        chk("beq_zero", {31'd0, bus.ex_mem_alu_zero}, 32'd1);
        chk("beq_target", bus.ex_mem_pc_branch, 32'h110);

        // J computes the jump target.
        bus.id_ex_jump_target = 26'h40;
        instr(0, 1, 2, 0, 0, 0, 0, 0, 0, 6'b000001);
        step();
        chk("j_target", bus.ex_mem_pc_jump, 32'h100);

        // MUL 0xFFFF * 0x10001 stalls for 33 cycles, then writes its result.
        instr(9, 1, 2, 8, 32'hFFFF, 32'h10001, 0, 0, 1, 6'b100000);
        stall_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (bus.ex_stall !== 1'b1) break;
            stall_cycles++;
            #0 ; // still inside the current cycle
            step();
            k = k; // keep loop body simple
        end
        chk("mul_stall_33", stall_cycles, 33);
        step();
        chk("mul_result", bus.ex_mem_alu_out, 32'hFFFFFFFF);
        chk("mul_rw", {31'd0, bus.ex_mem_ctrl_reg_write}, 32'd1);

        // Flush during BUSY cycle 10.
        instr(9, 1, 2, 8, 32'h1234, 32'h5678, 0, 0, 1, 6'b100000);
        for (int k = 0; k < 10; k++) step();
        bus.flush = 1;
        step();
        chk("flush_stall", {31'd0, bus.ex_stall}, 32'd0);
        chk("flush_bubble", {31'd0, bus.ex_mem_ctrl_reg_write}, 32'd0);
        bus.flush = 0;
        instr(0, 1, 2, 9, 20, 22, 0, 0, 1, 6'b100000);
        step();
        chk("after_flush", bus.ex_mem_alu_out, 32'd42);

        // Asynchronous reset in the middle of a multiply.
        instr(9, 1, 2, 8, 32'h33, 32'h44, 0, 0, 1, 6'b100000);
        for (int k = 0; k < 5; k++) step();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_zero_state("async_rst");
        @(posedge clk); #1;
        rst_n = 1;
        instr(0, 1, 2, 3, 1, 2, 0, 0, 1, 6'b100000);
        step();
        chk("post_rst_add", bus.ex_mem_alu_out, 32'd3);

        // Randomized run. Inputs are held while the stage stalls, as the front end would hold them.
        for (int it = 0; it < 600; it++) begin
            if (!m_stall) begin
                instr(($urandom_range(0, 11) == 0) ? 4'd9 : 4'($urandom_range(0, 15)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 6'($urandom));
                bus.id_ex_valid = ($urandom_range(0, 9) != 0);
                bus.id_ex_pc_plus4 = $urandom;
                bus.id_ex_jump_target = 26'($urandom);
            end
            wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            bus.flush = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // A global bound guarantees that the run terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
